// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM state, line geometry helper and NOP encoding
// for the instruction line buffer (see IMEM_LINEBUF_2WAY_EN in top).
package imem_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } imem_state_e;

  function automatic int line_ofs_bits(input int words);
    return $clog2(words) + 2;
  endfunction

endpackage

// File: rtl/imem_line.sv
// imem_line: one line-buffer entry with a word write port and a
// combinational tag/word lookup port.
module imem_line
  import imem_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 28,
  parameter int IDX_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             clr,
  input  logic [TAG_W-1:0] lk_tag,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             hit,
  output logic [31:0]      lk_word
);

  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      words_q [LINE_WORDS];
  logic [31:0]      words_d [LINE_WORDS];

  // clear wins so a flush on the final beat leaves the line invalid
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    words_d = words_q;
    if (wr_en) words_d[wr_idx] = wr_data;
    if (set_en) begin
      valid_d = 1'b1;
      tag_d   = set_tag;
    end
    if (clr) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    words_q <= words_d;
  end

  assign hit     = valid_q && (tag_q == lk_tag);
  assign lk_word = words_q[lk_idx];

endmodule

// File: rtl/imem_linebuf.sv
// imem_linebuf: fetch-side line buffer with word-serial refill.
// IMEM_LINEBUF_2WAY_EN selects two associative entries instead of one.
module imem_linebuf
  import imem_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [31:0]       i_mem_data,
  output logic              i_mem_stall,
  input  logic              flush,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam int OFS = line_ofs_bits(LINE_WORDS);
  localparam int IW  = OFS - 2;
  localparam int TW  = ADDR_W - OFS;
`ifdef IMEM_LINEBUF_2WAY_EN
  localparam int NW  = 2;
`else
  localparam int NW  = 1;
`endif

  imem_state_e       state_q, state_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              vic;
  logic              fill_done;

  logic [TW-1:0]     lk_tag;
  logic [IW-1:0]     lk_idx;
  logic [NW-1:0]     hit, wr_en, set_en, clr, wsel;
  logic [31:0]       word [NW];
  logic              hit_any, last;
  logic              unused_ofs;

  assign lk_tag     = i_mem_addr[ADDR_W-1:OFS];
  assign lk_idx     = i_mem_addr[OFS-1:2];
  assign unused_ofs = ^i_mem_addr[1:0];
  assign last       = cnt_q == IW'(LINE_WORDS - 1);

  for (genvar w = 0; w < NW; w++) begin : g_way
    imem_line #(
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TW),
      .IDX_W     (IW)
    ) u_line (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en[w]),
      .wr_idx (cnt_q),
      .wr_data(bus_rdata),
      .set_en (set_en[w]),
      .set_tag(tag_q),
      .clr    (clr[w]),
      .lk_tag (lk_tag),
      .lk_idx (lk_idx),
      .hit    (hit[w]),
      .lk_word(word[w])
    );
  end

  always_comb begin
    hit_any    = 1'b0;
    i_mem_data = INST_NOP;
    for (int w = 0; w < NW; w++) begin
      if (hit[w]) begin
        hit_any    = 1'b1;
        i_mem_data = word[w];
      end
    end
  end

  assign i_mem_stall = !hit_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // final ack outranks flush: a late flush still ends the burst
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!hit_any) state_d = FILL;
      FILL: begin
        if (bus_ack && last) state_d = IDLE;
        else if (flush)      state_d = DRAIN;
      end
      DRAIN:   if (bus_ack && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;
    wr_en      = '0;
    set_en     = '0;
    fill_done  = 1'b0;
    clr        = {NW{flush}};
    for (int w = 0; w < NW; w++) wsel[w] = vic == 1'(w);
    case (state_q)
      IDLE: begin
        if (!hit_any) begin
          tag_d      = lk_tag;
          cnt_d      = '0;
          bus_req_d  = 1'b1;
          bus_addr_d = {lk_tag, OFS'(0)};
          clr        = clr | wsel;
        end
      end
      FILL, DRAIN: begin
        if (bus_ack) begin
          wr_en = wsel;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            bus_req_d = 1'b0;
            if (state_q == FILL && !flush) begin
              set_en    = wsel;
              fill_done = 1'b1;
            end
          end else begin
            bus_addr_d = bus_addr_q + ADDR_W'(4);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      cnt_q      <= '0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
    end else begin
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
    end
  end

`ifdef IMEM_LINEBUF_2WAY_EN
  logic vic_q, vic_d;

  assign vic_d = vic_q ^ fill_done;
  assign vic   = vic_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vic_q <= 1'b0;
    else     vic_q <= vic_d;
  end
`else
  logic unused_fill;

  assign vic         = 1'b0;
  assign unused_fill = fill_done;
`endif

  assign bus_req  = bus_req_q;
  assign bus_addr = bus_addr_q;

endmodule

// File: tb/tb_imem_linebuf.sv
// tb_imem_linebuf: directed bench with a queue-based line buffer model
// checked every cycle, plus literal expectations from the test plan.
module tb_imem_linebuf;
  import imem_pkg::*;

  localparam int LW = 4;
`ifdef IMEM_LINEBUF_2WAY_EN
  localparam int NW = 2;
`else
  localparam int NW = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        bus_ack = 1'b0;
  logic [31:0] i_mem_addr = '0;
  logic [31:0] i_mem_data, bus_addr, bus_rdata;
  logic        i_mem_stall, bus_req;
  logic [15:0] mem_gen = '0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] seen[$];
  logic [31:0] held_addr = '0;

  imem_linebuf #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_mem_addr (i_mem_addr),
    .i_mem_data (i_mem_data),
    .i_mem_stall(i_mem_stall),
    .flush      (flush),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  assign bus_rdata = 32'hA0 + (bus_addr >> 2) + {mem_gen, 16'h0};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- model: contents per entry and a queue of outstanding beats ----
  logic        m_valid [2] = '{1'b0, 1'b0};
  logic [31:0] m_base  [2] = '{32'h0, 32'h0};
  logic [31:0] m_data  [2][LW];
  logic        m_vic = 1'b0;
  logic        m_abort = 1'b0;
  int          m_way = 0;
  logic [31:0] m_fbase = '0;
  logic [31:0] pend[$];

  function automatic logic [31:0] lbase(input logic [31:0] a);
    return a & ~(32'(LW * 4) - 32'd1);
  endfunction

  function automatic logic m_hit(input logic [31:0] a,
                                 output logic [31:0] d);
    m_hit = 1'b0;
    d = INST_NOP;
    for (int w = 0; w < NW; w++) begin
      if (m_valid[w] && m_base[w] == lbase(a)) begin
        m_hit = 1'b1;
        d = m_data[w][(a >> 2) % LW];
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    logic        h;
    logic [31:0] d;
    int          bt;
    if (rst) begin
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
      m_vic = 1'b0;
      m_abort = 1'b0;
      pend.delete();
    end else begin
      h = m_hit(i_mem_addr, d);
      if (flush) begin
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
      end
      if (pend.size() > 0) begin
        if (flush) m_abort = 1'b1;
        if (bus_ack) begin
          bt = LW - pend.size();
          m_data[m_way][bt] = bus_rdata;
          void'(pend.pop_front());
          if (pend.size() == 0 && !m_abort) begin
            m_valid[m_way] = 1'b1;
            m_base[m_way] = m_fbase;
            if (NW == 2) m_vic = !m_vic;
          end
        end
      end else if (!h) begin
        m_way = int'(m_vic);
        m_valid[m_way] = 1'b0;
        m_fbase = lbase(i_mem_addr);
        m_abort = 1'b0;
        for (int b = 0; b < LW; b++) pend.push_back(m_fbase + 32'(4 * b));
      end
    end
  end

  always @(negedge clk) begin
    logic        h;
    logic [31:0] d;
    if (!rst) begin
      h = m_hit(i_mem_addr, d);
      chk("cmp_stall", i_mem_stall, !h);
      chk("cmp_data", i_mem_data, d);
      chk("cmp_bus_req", bus_req, pend.size() > 0);
      if (pend.size() > 0) chk("cmp_bus_addr", bus_addr, pend[0]);
    end
  end

  always @(posedge clk) begin
    if (!rst && bus_req && bus_ack) seen.push_back(bus_addr);
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input int hb, input int hn,
                       output int n);
    int held;
    held = 0;
    i_mem_addr = a;
    seen.delete();
    n = 0;
    #1;
    while (i_mem_stall && n < 100) begin
      if (bus_req && seen.size() == hb && held < hn) begin
        bus_ack = 1'b0;
        held_addr = bus_addr;
        held++;
      end else begin
        bus_ack = 1'b1;
      end
      tick();
      n++;
    end
    bus_ack = 1'b0;
    chk("fetch_done", i_mem_stall, 1'b0);
  endtask

  initial begin
    int n;
    int stalls;
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_stall", i_mem_stall, 1'b1);
    chk("rst_data", i_mem_data, INST_NOP);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_addr", bus_addr, 32'h0);
    rst = 1'b0;

    fetch(32'h0, -1, 0, n);
    chk("t1_stall_cycles", n, 5);
    chk("t1_beats", seen.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_beat_addr", seen[i], 32'(4 * i));
    chk("t1_data", i_mem_data, 32'hA0);

    for (int i = 1; i < 4; i++) begin
      i_mem_addr = 32'(4 * i);
      #1;
      chk("hit_data", i_mem_data, 32'hA0 + 32'(i));
      chk("hit_stall", i_mem_stall, 1'b0);
      tick();
    end

    fetch(32'h10, -1, 0, n);
    chk("t2_first_addr", seen[0], 32'h10);
    chk("t2_stall_cycles", n, 5);
    chk("t2_data", i_mem_data, 32'hA4);

    fetch(32'h100, 2, 3, n);
    chk("hold_stall_cycles", n, 8);
    chk("hold_addr", held_addr, 32'h108);
    chk("hold_data", i_mem_data, 32'hE0);

    i_mem_addr = 32'h200;
    seen.delete();
    bus_ack = 1'b1;
    for (int i = 0; i < 20 && seen.size() < 1; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_gen = 16'h1;
    for (int i = 0; i < 20 && bus_req; i++) tick();
    chk("fl_beats", seen.size(), 4);
    chk("fl_still_miss", i_mem_stall, 1'b1);
    fetch(32'h200, -1, 0, n);
    chk("fl_refill_cycles", n, 5);
    chk("fl_refill_beats", seen.size(), 4);
    chk("fl_refill_data", i_mem_data, 32'h0001_0120);

    flush = 1'b1;
    #1;
    chk("idle_fl_pre", i_mem_stall, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    chk("idle_fl_post", i_mem_stall, 1'b1);
    fetch(32'h200, -1, 0, n);
    chk("idle_fl_refill", n, 5);

    i_mem_addr = 32'h0;
    seen.delete();
    bus_ack = 1'b1;
    for (int i = 0; i < 20 && seen.size() < 2; i++) tick();
    i_mem_addr = 32'h40;
    for (int i = 0; i < 40 && (seen.size() < 8 || i_mem_stall); i++) tick();
    bus_ack = 1'b0;
    for (int i = 0; i < 4; i++) chk("redir_old", seen[i], 32'(4 * i));
    chk("redir_new", seen[4], 32'h40);
    chk("redir_data", i_mem_data, 32'h0001_00B0);

    i_mem_addr = 32'h300;
    tick();
    tick();
    chk("pre_rst_req", bus_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", bus_req, 1'b0);
    chk("arst_addr", bus_addr, 32'h0);
    chk("arst_stall", i_mem_stall, 1'b1);
    i_mem_addr = 32'h0;
    tick();
    rst = 1'b0;

    fetch(32'h0, -1, 0, n);
    chk("w_fill0", n, 5);
    fetch(32'h10, -1, 0, n);
    chk("w_fill1", n, 5);
`ifdef IMEM_LINEBUF_2WAY_EN
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      i_mem_addr = i[0] ? 32'h10 : 32'h0;
      #1;
      if (i_mem_stall) stalls++;
      tick();
    end
    chk("alt_stalls", stalls, 0);
    fetch(32'h20, -1, 0, n);
    chk("evict_fill", n, 5);
    i_mem_addr = 32'h10;
    #1;
    chk("evict_keep", i_mem_stall, 1'b0);
    i_mem_addr = 32'h0;
    #1;
    chk("evict_gone", i_mem_stall, 1'b1);
    fetch(32'h0, -1, 0, n);
`else
    stalls = 0;
    i_mem_addr = 32'h0;
    #1;
    if (i_mem_stall) stalls++;
    chk("single_evict", stalls, 1);
    fetch(32'h0, -1, 0, n);
    chk("single_refill", n, 5);
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
